// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
// Shares one FIFO write port between NUM_REQ producers. Arbitration is
// round-robin, and each grant is limited to MAX_BURST beats before the port
// is re-arbitrated. The owner sees ready = ~fifo_full. FIFO write strobe and
// data are driven combinationally from the registered owner.
//
// Optional build macro: FIFO_ARB_STATS_EN
//   Adds stat_clr and stat_cnt, which provide per-requester saturating 16-bit
//   counters of accepted beats. stat_clr is a synchronous clear and takes
//   priority over a transfer in the same cycle.
//
// State table:
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | no owner; choose winner from rr_ptr onward; no transfer here
//   ST_GRANT | owner drives the FIFO; leave on valid drop or on last beat

module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr,
    output logic [DATA_WIDTH-1:0]         fifo_w_data,
`ifdef FIFO_ARB_STATS_EN
    input  logic                          stat_clr,
    output logic [NUM_REQ*16-1:0]         stat_cnt,
`endif
    output logic                          grant_valid,
    output logic [ID_WIDTH-1:0]           grant_id
);

    // Beat counter only has to reach MAX_BURST-1. It keeps at least one bit
    // so that a burst length of 1 still elaborates.
    localparam int BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]          r_state;
    logic [ID_WIDTH-1:0] r_rr_ptr;
    logic [ID_WIDTH-1:0] r_owner;
    logic [BEAT_W-1:0]   r_beat_cnt;
    logic                r_grant_valid;
    logic [ID_WIDTH-1:0] r_grant_id;

    logic                  w_in_grant;
    logic                  w_any_req;
    logic [ID_WIDTH-1:0]   w_winner;
    logic                  w_owner_valid;
    logic [DATA_WIDTH-1:0] w_owner_data;
    logic                  w_xfer;
    logic                  w_last_beat;
    logic                  w_exit;
    logic [ID_WIDTH-1:0]   w_next_ptr;

    logic [DATA_WIDTH-1:0] w_data_arr [NUM_REQ];

    // Unpack the flat data bus so that the owner can be selected by index.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_in_grant    = (r_state == ST_GRANT);
    assign w_owner_valid = req_valid[r_owner];
    assign w_owner_data  = w_data_arr[r_owner];

    // Round-robin scan that starts at rr_ptr. The scan runs from the far end
    // backwards, so the nearest asserted requester is assigned last and wins.
    always_comb begin
        w_any_req = 1'b0;
        w_winner  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                w_any_req = 1'b1;
                w_winner  = ID_WIDTH'(idx);
            end
        end
    end

    // Exit conditions from GRANT and the pointer that follows the owner.
    always_comb begin
        w_xfer      = w_in_grant && w_owner_valid && !fifo_full;
        w_last_beat = (r_beat_cnt == BEAT_W'(MAX_BURST - 1));
        // A dropped valid always exits, even while the FIFO is full. A full
        // FIFO on its own only stalls the burst.
        w_exit      = !w_owner_valid || (w_xfer && w_last_beat);
        if (r_owner == ID_WIDTH'(NUM_REQ - 1)) begin
            w_next_ptr = '0;
        end else begin
            w_next_ptr = r_owner + ID_WIDTH'(1);
        end
    end

    // Port-facing outputs. In IDLE all of them are forced to zero.
    always_comb begin
        req_ready   = '0;
        fifo_wr     = 1'b0;
        fifo_w_data = '0;
        if (w_in_grant) begin
            req_ready[r_owner] = !fifo_full;
            fifo_wr            = w_xfer;
            fifo_w_data        = w_owner_data;
        end
    end

    // Arbitration FSM. Asserting reset abandons any burst that is in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_rr_ptr      <= '0;
            r_owner       <= '0;
            r_beat_cnt    <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner       <= w_winner;
                        r_grant_id    <= w_winner;
                        r_grant_valid <= 1'b1;
                        r_beat_cnt    <= '0;
                        r_state       <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_exit) begin
                        r_rr_ptr      <= w_next_ptr;
                        r_grant_valid <= 1'b0;
                        r_beat_cnt    <= '0;
                        r_state       <= ST_IDLE;
                    end else if (w_xfer) begin
                        r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant_valid = r_grant_valid;
    assign grant_id    = r_grant_id;

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] r_stat [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        // Per-requester accepted-beat counter. Clear wins over increment,
        // and the count sticks at all-ones.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_stat[g] <= '0;
            end else if (stat_clr) begin
                r_stat[g] <= '0;
            end else if (fifo_wr && (r_owner == ID_WIDTH'(g)) && (r_stat[g] != 16'hFFFF)) begin
                r_stat[g] <= r_stat[g] + 16'd1;
            end
        end
        assign stat_cnt[g*16 +: 16] = r_stat[g];
    end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Testbench for fifo_write_arbiter. Producers are modelled as per-requester
// data queues. Each expected FIFO write (requester id, data) goes into a
// scoreboard when the stimulus is loaded, and comes out when fifo_wr is seen.
module tb_fifo_write_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int MAX_BURST  = 4;
    localparam int ID_WIDTH   = 2;

    logic                          clk;
    logic                          reset;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_wr;
    logic [DATA_WIDTH-1:0]         fifo_w_data;
    logic                          grant_valid;
    logic [ID_WIDTH-1:0]           grant_id;
`ifdef FIFO_ARB_STATS_EN
    logic                          stat_clr;
    logic [NUM_REQ*16-1:0]         stat_cnt;
`endif

    fifo_write_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_WIDTH(DATA_WIDTH),
        .MAX_BURST (MAX_BURST),
        .ID_WIDTH  (ID_WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr    (fifo_wr),
        .fifo_w_data(fifo_w_data),
`ifdef FIFO_ARB_STATS_EN
        .stat_clr   (stat_clr),
        .stat_cnt   (stat_cnt),
`endif
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
    } sb_t;

    sb_t sb_q [$];

    logic [DATA_WIDTH-1:0] src_mem  [NUM_REQ][16];
    int                    src_head [NUM_REQ];
    int                    src_tail [NUM_REQ];

    int n_checks = 0;
    int n_errors = 0;
    int n_writes = 0;

    logic                  s_wr;
    logic [NUM_REQ-1:0]    s_ready;
    logic                  s_gv;
    logic [ID_WIDTH-1:0]   s_gid;
    logic [DATA_WIDTH-1:0] s_data;
    logic [NUM_REQ-1:0]    fire;
    int                    used;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_head[i] != src_tail[i]) begin
                req_valid[i] = 1'b1;
                req_data[i*DATA_WIDTH +: DATA_WIDTH] = src_mem[i][src_head[i]];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
        end
    endtask

    task automatic push_src(input int r, input logic [DATA_WIDTH-1:0] d);
        src_mem[r][src_tail[r]] = d;
        src_tail[r]++;
    endtask

    task automatic expect_wr(input int r, input logic [DATA_WIDTH-1:0] d);
        sb_t e;
        e.id   = ID_WIDTH'(r);
        e.data = d;
        sb_q.push_back(e);
    endtask

    // One clock: sample on the falling edge, score writes, then advance the
    // producers that handshook on the following rising edge.
    task automatic step();
        sb_t e;
        @(negedge clk);
        s_wr   = fifo_wr;
        s_ready = req_ready;
        s_gv   = grant_valid;
        s_gid  = grant_id;
        s_data = fifo_w_data;
        fire   = req_valid & req_ready;
        if (s_wr) begin
            n_writes++;
            if (sb_q.size() == 0) begin
                check("unexpected_write", 64'(s_data), 64'hFFFF);
            end else begin
                e = sb_q.pop_front();
                check("wr_data", 64'(s_data), 64'(e.data));
                check("wr_id", 64'(s_gid), 64'(e.id));
                check("wr_ready", 64'(s_ready), 64'(1) << e.id);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (fire[i]) src_head[i]++;
        end
        drive_inputs();
    endtask

    task automatic run_writes(input int n, input int bound, output int cycles);
        int start;
        start  = n_writes;
        cycles = 0;
        while ((n_writes - start) < n && cycles < bound) begin
            step();
            cycles++;
        end
        if ((n_writes - start) < n) begin
            check("timeout_writes", 64'(n_writes - start), 64'(n));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        fifo_full = 1'b0;
        req_valid = '0;
        req_data  = '0;
`ifdef FIFO_ARB_STATS_EN
        stat_clr  = 1'b0;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            src_head[i] = 0;
            src_tail[i] = 0;
        end

        // Reset with every requester valid. The traffic then forms the
        // round-robin test: req0 has 8 items and the others have 4 each.
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int k = 0; k < ((i == 0) ? 8 : 4); k++) begin
                push_src(i, DATA_WIDTH'(i*16 + k + 1));
            end
        end
        for (int g = 0; g < NUM_REQ; g++) begin
            for (int k = 0; k < 4; k++) expect_wr(g, DATA_WIDTH'(g*16 + k + 1));
        end
        for (int k = 4; k < 8; k++) expect_wr(0, DATA_WIDTH'(k + 1));
        drive_inputs();

        for (int c = 0; c < 2; c++) begin
            step();
            check("rst_ready", 64'(s_ready), 64'h0);
            check("rst_wr", 64'(s_wr), 64'h0);
            check("rst_gv", 64'(s_gv), 64'h0);
            check("rst_gid", 64'(s_gid), 64'h0);
            check("rst_wdata", 64'(s_data), 64'h0);
        end
        reset = 1'b1;
        step();
        check("rel_idle_gv", 64'(s_gv), 64'h0);
        check("rel_idle_wr", 64'(s_wr), 64'h0);
        run_writes(20, 60, used);
        check("rr_cycles", 64'(used + 1), 64'd25);
`ifdef FIFO_ARB_STATS_EN
        check("stat_after_rr", 64'(stat_cnt), 64'h0004_0004_0004_0008);
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        check("stat_clear", 64'(stat_cnt), 64'h0);
`endif
        step();
        step();

        // Single requester with a 5-beat stream: a 4-beat burst, one idle
        // cycle, then a re-grant for the last beat.
        push_src(1, 8'd20); push_src(1, 8'd10); push_src(1, 8'd12);
        push_src(1, 8'd11); push_src(1, 8'd9);
        expect_wr(1, 8'd20); expect_wr(1, 8'd10); expect_wr(1, 8'd12);
        expect_wr(1, 8'd11); expect_wr(1, 8'd9);
        drive_inputs();
        run_writes(5, 20, used);
        check("single_cycles", 64'(used), 64'd7);
        step();
        step();

        // Full stall: the burst goes 2 beats, stalls for 3 cycles, then completes.
        for (int k = 0; k < 4; k++) begin
            push_src(2, DATA_WIDTH'(8'hA0 + k));
            expect_wr(2, DATA_WIDTH'(8'hA0 + k));
        end
        drive_inputs();
        run_writes(2, 10, used);
        check("stall_first_cycles", 64'(used), 64'd3);
        fifo_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("stall_wr", 64'(s_wr), 64'h0);
            check("stall_ready", 64'(s_ready), 64'h0);
            check("stall_gv", 64'(s_gv), 64'h1);
            check("stall_gid", 64'(s_gid), 64'd2);
        end
        fifo_full = 1'b0;
        run_writes(2, 5, used);
        check("stall_resume_cycles", 64'(used), 64'd2);
        step();
        step();

        // Early release: req0 gives 2 beats and drops. req3 appears after
        // req0 is granted and is chosen next because the scan starts at 1.
        push_src(0, 8'h55); push_src(0, 8'h66);
        expect_wr(0, 8'h55); expect_wr(0, 8'h66);
        drive_inputs();
        step();
        check("early_idle_gv", 64'(s_gv), 64'h0);
        push_src(3, 8'h77); push_src(3, 8'h88);
        expect_wr(3, 8'h77); expect_wr(3, 8'h88);
        drive_inputs();
        run_writes(4, 12, used);
        check("early_cycles", 64'(used), 64'd6);
        step();
        step();

        // Reset asserted mid-burst: the burst is abandoned and nothing is written.
        for (int k = 0; k < 4; k++) push_src(1, DATA_WIDTH'(8'hC0 + k));
        expect_wr(1, 8'hC0); expect_wr(1, 8'hC1);
        drive_inputs();
        run_writes(2, 8, used);
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            check("midrst_wr", 64'(s_wr), 64'h0);
            check("midrst_ready", 64'(s_ready), 64'h0);
            check("midrst_gv", 64'(s_gv), 64'h0);
            check("midrst_wdata", 64'(s_data), 64'h0);
        end
        for (int i = 0; i < NUM_REQ; i++) src_head[i] = src_tail[i];
        drive_inputs();
        reset = 1'b1;
        step();
        check("post_rst_gv", 64'(s_gv), 64'h0);
        check("post_rst_wr", 64'(s_wr), 64'h0);

        check("sb_empty", 64'(sb_q.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the write port of one FIFO between NUM_REQ producers using round-robin arbitration with bounded bursts.
- Sits directly in front of the FIFO. Drives its wr/w_data, observes its full flag, and returns valid/ready backpressure to each producer.
- Read side of the FIFO is untouched.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, data width; matches FIFO w_data
- MAX_BURST, 4, max beats per grant before forced re-arbitration (>=1)
- ID_WIDTH, 2, width of grant_id; must satisfy 2**ID_WIDTH >= NUM_REQ

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- req_valid  input  NUM_REQ  per-requester data valid
- req_data  input  NUM_REQ*DATA_WIDTH  packed data; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero
- fifo_full  input  1  FIFO full flag
- fifo_wr  output  1  FIFO write strobe
- fifo_w_data  output  DATA_WIDTH  FIFO write data
- grant_valid  output  1  a requester currently owns the FIFO port (registered)
- grant_id  output  ID_WIDTH  index of owner; valid when grant_valid=1 (registered)

Behaviour:
- Reset (reset=0, async): state=IDLE, rr_ptr=0, owner=0, beat_cnt=0, grant_valid=0, grant_id=0. Consequently req_ready=0, fifo_wr=0, fifo_w_data=0.
- FSM states: IDLE, GRANT.
- IDLE, arbitration:
  - If any req_valid=1, the winner is the first asserted index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Next cycle: owner<=winner, grant_id<=winner, grant_valid<=1, beat_cnt<=0, state<=GRANT.
  - No transfer occurs in IDLE; arbitration latency is 1 cycle.
  - fifo_full does not block arbitration.
- GRANT:
  - req_ready[owner] = ~fifo_full; all other req_ready = 0.
  - fifo_wr = req_valid[owner] & ~fifo_full.
  - fifo_w_data = req_data[owner] whenever in GRANT, else 0.
  - These outputs are combinational from registered state plus inputs.
  - Transfer = fifo_wr=1; a transfer increments beat_cnt.
- Exit GRANT to IDLE when either:
  - (a) req_valid[owner]=0, with no transfer that cycle; or
  - (b) a transfer occurs with beat_cnt=MAX_BURST-1.
- On exit: rr_ptr<=(owner+1) mod NUM_REQ, grant_valid<=0, beat_cnt<=0.
- fifo_full=1 in GRANT: stall. No transfer, beat_cnt holds, state holds, no exit even if other requesters wait. Exit (a) still applies if the owner drops valid.
- Fairness: a continuously requesting producer receives at most MAX_BURST beats. It then waits for every other active requester's grant before its next one. Minimum bus bubble between grants is 1 cycle (the IDLE cycle).
- The pointer update uses modulo wrap: owner=NUM_REQ-1 gives rr_ptr=0.
- A requester's valid may drop at any time. It must hold data stable while valid=1 and ready=0.
- Reset asserted mid-burst: immediate return to reset values. A partially issued burst is abandoned; no write occurs during reset.

Optional Feature:
- Macro FIFO_ARB_STATS_EN.
- When defined, adds:
  - input stat_clr (1): synchronous clear of all counters.
  - output stat_cnt (NUM_REQ*16): per-requester 16-bit counters of accepted beats, packed like req_data.
- Counter behaviour: saturates at 16'hFFFF. Resets to 0 on reset. stat_clr in the same cycle as a transfer clears the counter (clear wins).
- When undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold reset=0 with req_valid=4'b1111 -> req_ready=0, fifo_wr=0, grant_valid=0. Release reset -> one IDLE cycle, then grant_id=0.
- Single requester: req1 streams 8'd20, 8'd10, 8'd12, 8'd11, 8'd9 continuously, MAX_BURST=4, fifo_full=0 -> 4 writes of 20, 10, 12, 11 with grant_id=1. Then 1 idle cycle, then 9 written on the re-grant to req1.
- Round-robin: all four valid continuously, fifo_full=0 -> grant_id sequence 0, 1, 2, 3, 0. Each grant gives 4 beats separated by one idle cycle; 20 writes in 25 cycles.
- Full stall: req2 owner, fifo_full=1 for 3 cycles mid-burst after 2 beats -> fifo_wr=0 and req_ready=0 for 3 cycles, grant_id stays 2. Two more beats complete after full deasserts.
- Early release: req0 valid for 2 beats then drops while req3 is valid -> exit after 2 beats. Next grant_id=3 (rr_ptr=1 scan skips idle 1, 2).
- Stats (FIFO_ARB_STATS_EN): after the round-robin test, stat_cnt={16'd4, 16'd4, 16'd4, 16'd8}, with req0 at the LSBs. Pulse stat_clr -> all counters 0 the next cycle.
